// File: rtl/fetch_unit.sv
// fetch_unit: FETCH/EXEC/HALT instruction fetch sequencer with next-PC selection.
// Define FETCH_COUNT_EN to build the saturating retirement counter; otherwise fetch_count is 0.
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h00000000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        i_hit,
    input  logic [31:0] iload,
    input  logic        d_hit,
    input  logic        dmem_busy,
    input  logic [1:0]  PCSrc,
    input  logic [15:0] imm16,
    input  logic [25:0] j_addr26,
    input  logic [31:0] jr_addr,
    input  logic        halt,
    output logic        i_ren,
    output logic [31:0] iaddr,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        halted,
    output logic [31:0] fetch_count
);
    localparam logic [1:0] FETCH = 2'd0, EXEC = 2'd1, HALT = 2'd2;
    logic [1:0]  state;
    logic [31:0] next_pc, br_off;
    logic        retire;

    assign pc4         = pc + 32'd4;
    assign iaddr       = pc;
    assign i_ren       = (state == FETCH) && !RST;
    assign instr_valid = (state == EXEC) && !RST;
    assign halted      = (state == HALT);
    assign retire      = (state == EXEC) && !halt && (!dmem_busy || d_hit);
    assign br_off      = {{14{imm16[15]}}, imm16, 2'b00};

    always_comb begin
        next_pc = (PCSrc == 2'd0) ? pc4 :
                  (PCSrc == 2'd1) ? pc4 + br_off :
                  (PCSrc == 2'd2) ? {pc4[31:28], j_addr26, 2'b00} :
                                    {jr_addr[31:2], 2'b00};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= FETCH;
            pc    <= PC_INIT;
            instr <= '0;
        end else if (state == FETCH) begin
            if (i_hit) begin
                instr <= iload;
                state <= EXEC;
            end
        end else if (state == EXEC) begin
            if (halt) state <= HALT;
            else if (retire) begin
                pc    <= next_pc;
                state <= FETCH;
            end
        end
    end

`ifdef FETCH_COUNT_EN
    logic [31:0] count;
    assign fetch_count = count;
    always_ff @(posedge CLK) begin
        if (RST) count <= '0;
        else if (retire && count != 32'hFFFFFFFF) count <= count + 32'd1;
    end
`else
    assign fetch_count = 32'd0;
`endif
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_INIT, default 32'h00000000, meaning the PC value loaded on reset.
REQ-002 SHALL have port CLK  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_hit  input  1  instruction memory has returned iload for iaddr this cycle.
REQ-005 SHALL have port iload  input  32  instruction word from instruction memory.
REQ-006 SHALL have port d_hit  input  1  data access completed this cycle.
REQ-007 SHALL have port dmem_busy  input  1  a data read/write request is outstanding (ru_dren_out | ru_dwen_out).
REQ-008 SHALL have port PCSrc  input  2  next-PC select: 0 PC4, 1 BRANCH (taken), 2 JUMP, 3 JR.
REQ-009 SHALL have ports imm16 (16), j_addr26 (26), jr_addr (32)  input  branch offset, jump index, register jump target.
REQ-010 SHALL have port halt  input  1  decoded halt from the control unit.
REQ-011 SHALL have ports i_ren (1) and iaddr (32)  output  instruction read request and address.
REQ-012 SHALL have ports instr (32) and instr_valid (1)  output  held instruction for decode, and its qualifier.
REQ-013 SHALL have ports pc (32) and pc4 (32)  output  current PC and PC+4 (jal link value).
REQ-014 SHALL have port halted  output  1  sticky halt indication.
REQ-015 SHALL have port fetch_count  output  32  count of instructions retired.

Function
REQ-016 SHALL implement states FETCH, EXEC, HALT.
REQ-017 FETCH: i_ren=1, iaddr=pc, instr_valid=0; on i_hit SHALL capture iload into instr and go to EXEC next cycle (one-cycle latency from i_hit to instr_valid=1).
REQ-018 FETCH with i_hit=0 SHALL hold pc and state indefinitely.
REQ-019 EXEC: i_ren=0, instr_valid=1, instr stable for the whole state.
REQ-020 EXEC with halt=1 SHALL go to HALT, pc unchanged, regardless of dmem_busy.
REQ-021 EXEC with halt=0 and dmem_busy=1 and d_hit=0 SHALL stay in EXEC (retire stall).
REQ-022 EXEC with halt=0 and (dmem_busy=0 or d_hit=1) SHALL retire: pc <= next_pc, go to FETCH, fetch_count increments.
REQ-023 next_pc SHALL be: PC4 -> pc+4; BRANCH -> pc4 + (sign-extended imm16 << 2); JUMP -> {pc4[31:28], j_addr26, 2'b00}; JR -> {jr_addr[31:2], 2'b00}.
REQ-024 All PC arithmetic SHALL be 32-bit modulo 2^32 (pc 32'hFFFFFFFC + 4 = 32'h00000000).
REQ-025 pc4 SHALL be combinationally pc+4 at all times.
REQ-026 HALT SHALL be absorbing: i_ren=0, instr_valid=0, halted=1, pc and fetch_count frozen until RST.
REQ-027 PCSrc, imm16, j_addr26, jr_addr SHALL be sampled only in the retire cycle; other-cycle values are ignored.

Reset
REQ-028 RST=1 at a clock edge SHALL set state=FETCH, pc=PC_INIT, instr=0, halted=0, fetch_count=0, overriding any other event that cycle.
REQ-029 While RST=1, i_ren SHALL be 0 and instr_valid 0; reset asserted mid-fetch or mid-stall SHALL abandon the access with no retire.
REQ-030 First i_ren after reset SHALL be the cycle following RST deassertion, iaddr=PC_INIT.

Configuration
REQ-031 Macro FETCH_COUNT_EN: defined -> fetch_count is a 32-bit counter of retirements that saturates at 32'hFFFFFFFF; undefined -> no counter logic, fetch_count tied to 0.

Verification
REQ-032 Reset then i_hit held 1, PCSrc=0, no data ops -> iaddr sequence 0,4,8, each FETCH/EXEC pair two cycles, fetch_count 1,2,3 (macro on).
REQ-033 pc=32'h40, PCSrc=1, imm16=16'hFFFE -> next iaddr 32'h3C; imm16=16'h0003 -> 32'h50.
REQ-034 pc=32'h00400010, PCSrc=2, j_addr26=26'h0000100 -> next iaddr 32'h00000400; PCSrc=3, jr_addr=32'h123 -> 32'h120.
REQ-035 EXEC with dmem_busy=1, d_hit low 3 cycles then high -> pc unchanged 3 cycles, retire on d_hit cycle, i_ren next cycle.
REQ-036 halt=1 in EXEC at pc=32'h20 -> halted=1 next cycle, i_ren stays 0 for 10 cycles; RST pulse -> iaddr=PC_INIT, halted=0.
REQ-037 pc=32'hFFFFFFFC, PCSrc=0 retire -> iaddr 32'h00000000; RST during 5-cycle i_hit=0 wait -> no retire, fetch_count=0.
